// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE result collector.
//   PARA_INT_BITS / PARA_FRAC_BITS : default result word split
//   DATA_W                         : result word width (int + frac bits)
//   IDX_W                          : width of accumulator index / slot index
//   FRAME_W                        : width of the completed-frame counter
//   pe_col_state_e                 : collector FSM state (COLLECT, DRAIN)
//   pe_word_t                      : result word at default width
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int PARA_INT_BITS  = 7;
    localparam int PARA_FRAC_BITS = 9;

    function automatic int data_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    localparam int DATA_W  = data_w(PARA_INT_BITS, PARA_FRAC_BITS);
    localparam int IDX_W   = 4;
    localparam int FRAME_W = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } pe_col_state_e;

    typedef logic [DATA_W-1:0] pe_word_t;

endpackage

// File: rtl/pe_result_buf.sv
// ---------------------------------------------------------------------------
// pe_result_buf
// NUM_ACC x DATA_W register file with one valid bit per slot.
//   clk, rst        : clock, asynchronous active-high reset (data and valid -> 0)
//   clr             : synchronous clear of all valid bits (data left as is)
//   wr_en/idx/data  : write port; sets the slot's valid bit
//   clr_en/clr_idx  : clear-by-index port; drops the slot's valid bit only
//   rd_idx/rd_data  : asynchronous read port
//   vld             : per-slot valid bits
// The caller guarantees wr and clr-by-index never target the same slot in
// the same cycle; if they did, the write wins.
// ---------------------------------------------------------------------------
module pe_result_buf #(
    parameter int NUM_ACC = 8,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [3:0]         wr_idx,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               clr_en,
    input  logic [3:0]         clr_idx,
    input  logic [3:0]         rd_idx,
    output logic [DATA_W-1:0]  rd_data,
    output logic [NUM_ACC-1:0] vld
);

    logic [DATA_W-1:0] mem [NUM_ACC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (wr_en && (wr_idx == 4'(i))) begin
                    mem[i] <= wr_data;
                    vld[i] <= 1'b1;
                end else if (clr_en && (clr_idx == 4'(i))) begin
                    vld[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/pe_result_collector.sv
// ---------------------------------------------------------------------------
// pe_result_collector
// Collects rounded PE results into one slot per accumulator register. When
// every slot is filled the frame is streamed out in slot order, and the PE is
// held off (keep) for as long as the frame is draining.
//   clk, rst       : clock, asynchronous active-high reset
//   clr            : synchronous clear (buffer emptied, errors and frame count 0)
//   rounder_valid  : PE result strobe
//   round_number   : accumulator index of the result
//   data_in        : rounded result word
//   keep           : hold request to the PE, registered (state == DRAIN)
//   out_valid/out_ready/out_data/out_index/out_last : output stream
//   frame_cnt      : number of completed frames (wraps)
//   err_idx        : sticky, strobe with index >= NUM_ACC
//   err_ovw        : sticky, strobe to an occupied or not yet drained slot
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_valid, out_data,
// out_index and out_last hold their values until that transfer.
// ---------------------------------------------------------------------------
module pe_result_collector
    import pe_pkg::*;
#(
    parameter int para_int_bits  = PARA_INT_BITS,
    parameter int para_frac_bits = PARA_FRAC_BITS,
    parameter int NUM_ACC        = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clr,
    input  logic                                      rounder_valid,
    input  logic [3:0]                                round_number,
    input  logic [data_w(para_int_bits, para_frac_bits)-1:0] data_in,
    output logic                                      keep,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [data_w(para_int_bits, para_frac_bits)-1:0] out_data,
    output logic [3:0]                                out_index,
    output logic                                      out_last,
    output logic [15:0]                               frame_cnt,
    output logic                                      err_idx,
    output logic                                      err_ovw
);

    localparam int         DW       = data_w(para_int_bits, para_frac_bits);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ACC - 1);

    pe_col_state_e state_q, state_d;
    logic [3:0]    ptr_q, ptr_d;
    logic [15:0]   frame_q, frame_d;
    logic          err_idx_q, err_idx_d;
    logic          err_ovw_q, err_ovw_d;

    logic [NUM_ACC-1:0] vld;
    logic [NUM_ACC-1:0] wr_mask;
    logic [NUM_ACC-1:0] clr_mask;
    logic [NUM_ACC-1:0] vld_next;
    logic [DW-1:0]      rd_data;

    logic idx_ok;
    logic slot_busy;
    logic in_window;
    logic wr_en;
    logic hs;

    // ------------------------------------------------------------------
    // Write acceptance. In DRAIN only slots already handed out (idx < ptr)
    // may be refilled; this absorbs the strobes still in flight in the PE
    // pipeline after keep rises without disturbing the word on the port.
    // ------------------------------------------------------------------
    always_comb begin
        slot_busy = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (round_number == 4'(i)) begin
                slot_busy = vld[i];
            end
        end
    end

    assign idx_ok    = ({1'b0, round_number} < 5'(NUM_ACC));
    assign in_window = (state_q == COLLECT) || (round_number < ptr_q);
    assign wr_en     = rounder_valid && !clr && idx_ok && !slot_busy && in_window;
    assign hs        = (state_q == DRAIN) && out_ready;

    // Valid bits as they will be after this edge; used to detect the
    // completing write so DRAIN starts on that same edge.
    always_comb begin
        wr_mask  = '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            wr_mask[i]  = wr_en && (round_number == 4'(i));
            clr_mask[i] = hs && (ptr_q == 4'(i));
        end
        vld_next = (vld & ~clr_mask) | wr_mask;
    end

    pe_result_buf #(
        .NUM_ACC (NUM_ACC),
        .DATA_W  (DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_idx  (round_number),
        .wr_data (data_in),
        .clr_en  (hs),
        .clr_idx (ptr_q),
        .rd_idx  (ptr_q),
        .rd_data (rd_data),
        .vld     (vld)
    );

    // ------------------------------------------------------------------
    // FSM, drain pointer, frame counter, sticky errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            ptr_q     <= '0;
            frame_q   <= '0;
            err_idx_q <= 1'b0;
            err_ovw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            frame_q   <= frame_d;
            err_idx_q <= err_idx_d;
            err_ovw_q <= err_ovw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        frame_d   = frame_q;
        err_idx_d = err_idx_q;
        err_ovw_d = err_ovw_q;

        if (clr) begin
            // Strobes in the clear cycle are discarded silently.
            state_d   = COLLECT;
            ptr_d     = '0;
            frame_d   = '0;
            err_idx_d = 1'b0;
            err_ovw_d = 1'b0;
        end else begin
            if (rounder_valid && !idx_ok) begin
                err_idx_d = 1'b1;
            end
            if (rounder_valid && idx_ok && !wr_en) begin
                err_ovw_d = 1'b1;
            end

            unique case (state_q)
                COLLECT: begin
                    // Also covers a frame completely pre-filled during the
                    // previous DRAIN: re-enter DRAIN on the next edge.
                    if (&vld_next) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (ptr_q == LAST_IDX) begin
                            ptr_d   = '0;
                            frame_d = frame_q + 16'd1;
                            state_d = COLLECT;
                        end else begin
                            ptr_d = ptr_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registers, no combinational input path.
    // ------------------------------------------------------------------
    always_comb begin
        keep      = (state_q == DRAIN);
        out_valid = (state_q == DRAIN);
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (state_q == DRAIN) begin
            out_data  = rd_data;
            out_index = ptr_q;
            out_last  = (ptr_q == LAST_IDX);
        end
    end

    assign frame_cnt = frame_q;
    assign err_idx   = err_idx_q;
    assign err_ovw   = err_ovw_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_result_collector
// Directed bench for pe_result_collector (NUM_ACC = 8, 16-bit words).
// A behavioural model tracks slot contents, drain position, frame count and
// error flags from the block's rules; a negedge process compares every output
// against it each cycle. Drained words are also captured and checked against
// hand-built expected frames, and a few literal values pin the model.
// ---------------------------------------------------------------------------
module tb_pe_result_collector;

    localparam int DW = pe_pkg::DATA_W;
    localparam int NA = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          rounder_valid = 1'b0;
    logic [3:0]    round_number = '0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b0;
    logic          keep;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_index;
    logic          out_last;
    logic [15:0]   frame_cnt;
    logic          err_idx;
    logic          err_ovw;

    int n_cmp  = 0;
    int n_fail = 0;

    pe_result_collector #(
        .para_int_bits  (7),
        .para_frac_bits (9),
        .NUM_ACC        (NA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .rounder_valid (rounder_valid),
        .round_number  (round_number),
        .data_in       (data_in),
        .keep          (keep),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last),
        .frame_cnt     (frame_cnt),
        .err_idx       (err_idx),
        .err_ovw       (err_ovw)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Slot contents and fill flags, how far the current frame has been handed
    // out, and whether a frame is being handed out.
    logic [DW-1:0] m_buf [16];
    bit            m_full [16];
    bit            m_draining = 1'b0;
    int            m_ptr = 0;
    logic [15:0]   m_frame = '0;
    bit            m_err_idx = 1'b0;
    bit            m_err_ovw = 1'b0;
    bit            m_was_draining;
    int            m_filled;

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_buf[i]  = '0;
            m_full[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_buf[i]  = '0;
                m_full[i] = 1'b0;
            end
            m_draining = 1'b0;
            m_ptr      = 0;
            m_frame    = '0;
            m_err_idx  = 1'b0;
            m_err_ovw  = 1'b0;
        end else if (clr) begin
            for (int i = 0; i < 16; i++) m_full[i] = 1'b0;
            m_draining = 1'b0;
            m_ptr      = 0;
            m_frame    = '0;
            m_err_idx  = 1'b0;
            m_err_ovw  = 1'b0;
        end else begin
            m_was_draining = m_draining;
            if (rounder_valid) begin
                if (int'(round_number) >= NA) begin
                    m_err_idx = 1'b1;
                end else if (m_full[round_number] ||
                             (m_was_draining && int'(round_number) >= m_ptr)) begin
                    m_err_ovw = 1'b1;
                end else begin
                    m_buf[round_number]  = data_in;
                    m_full[round_number] = 1'b1;
                end
            end
            if (m_was_draining) begin
                if (out_ready) begin
                    m_full[m_ptr] = 1'b0;
                    if (m_ptr == NA - 1) begin
                        m_ptr      = 0;
                        m_draining = 1'b0;
                        m_frame    = m_frame + 16'd1;
                    end else begin
                        m_ptr = m_ptr + 1;
                    end
                end
            end else begin
                m_filled = 0;
                for (int i = 0; i < NA; i++) if (m_full[i]) m_filled++;
                if (m_filled == NA) m_draining = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    logic [DW+4:0] got_q [$];
    logic [DW+4:0] exp_q [$];
    int            keep_cycles = 0;

    always @(negedge clk) begin
        chk("keep",      32'(keep),      32'(m_draining));
        chk("out_valid", 32'(out_valid), 32'(m_draining));
        chk("out_data",  32'(out_data),  m_draining ? 32'(m_buf[m_ptr]) : 32'd0);
        chk("out_index", 32'(out_index), m_draining ? 32'(m_ptr) : 32'd0);
        chk("out_last",  32'(out_last),  32'(m_draining && (m_ptr == NA - 1)));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        chk("err_idx",   32'(err_idx),   32'(m_err_idx));
        chk("err_ovw",   32'(err_ovw),   32'(m_err_ovw));
        if (keep) keep_cycles++;
        if (out_valid && out_ready) got_q.push_back({out_last, out_index, out_data});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input int idx, input logic [DW-1:0] d);
        rounder_valid = 1'b1;
        round_number  = 4'(idx);
        data_in       = d;
        tick();
        rounder_valid = 1'b0;
        round_number  = '0;
        data_in       = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (keep && n < 60) begin
            tick();
            n++;
        end
        if (keep) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: keep still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] d);
        exp_q.push_back({(idx == NA - 1), 4'(idx), d});
    endtask

    task automatic check_frame(input string tag);
        logic [DW+4:0] e;
        logic [DW+4:0] g;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_word"}, 32'(g), 32'(e));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_outputs_idle(input string tag);
        chk({tag, "_keep"},      32'(keep),      32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_index"}, 32'(out_index), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int k0;

    initial begin
        tick();
        tick();
        check_outputs_idle("reset");
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_errs", 32'({err_idx, err_ovw}), 32'd0);
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a drain
        for (int i = 0; i < NA; i++) strobe(i, 16'(16'h0A00 + i));
        chk("t1_keep_up", 32'(keep), 32'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("t1_index_after3", 32'(out_index), 32'd3);
        rst = 1'b1;
        #1;
        check_outputs_idle("t1_rst");
        tick();
        rst = 1'b0;
        got_q.delete();
        tick();

        // 2: fill 7..0, drain with out_ready held high
        k0 = keep_cycles;
        for (int i = NA - 1; i >= 0; i--) strobe(i, 16'(16'h0100 * i));
        wait_idle();
        for (int i = 0; i < NA; i++) push_exp(i, 16'(16'h0100 * i));
        check_frame("t2");
        chk("t2_keep_cycles", 32'(keep_cycles - k0), 32'd8);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);

        // 3: backpressure pattern 1,0,0 repeating
        out_ready = 1'b0;
        for (int i = 0; i < NA; i++) strobe(i, 16'(16'hA000 + 16'h0011 * i));
        for (int k = 0; k < 60 && keep; k++) begin
            out_ready = ((k % 3) == 0);
            tick();
        end
        chk("t3_drained", 32'(keep), 32'd0);
        for (int i = 0; i < NA; i++) push_exp(i, 16'(16'hA000 + 16'h0011 * i));
        check_frame("t3");
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);

        // 4: strobes arriving after keep rises
        out_ready = 1'b1;
        for (int i = 0; i < NA; i++) strobe(i, 16'(16'h0400 + i));
        tick();                    // slot 0 handed out
        strobe(0, 16'h1234);       // ptr=1: slot 0 refill accepted
        strobe(5, 16'h5555);       // ptr=2: not yet drained, dropped
        chk("t4_err_ovw", 32'(err_ovw), 32'd1);
        wait_idle();
        for (int i = 0; i < NA; i++) push_exp(i, 16'(16'h0400 + i));
        check_frame("t4a");
        for (int i = 1; i < NA; i++) strobe(i, 16'(16'h0500 + i));
        wait_idle();
        push_exp(0, 16'h1234);
        for (int i = 1; i < NA; i++) push_exp(i, 16'(16'h0500 + i));
        check_frame("t4b");
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);

        // 5: error flags and clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_errs", 32'({err_idx, err_ovw}), 32'd0);
        strobe(9, 16'hDEAD);
        chk("t5_err_idx", 32'(err_idx), 32'd1);
        chk("t5_err_ovw_clean", 32'(err_ovw), 32'd0);
        strobe(3, 16'h0333);
        strobe(3, 16'h0999);
        chk("t5_err_ovw", 32'(err_ovw), 32'd1);
        for (int i = 0; i < NA; i++) if (i != 3) strobe(i, 16'(16'h0600 + i));
        wait_idle();
        for (int i = 0; i < NA; i++) push_exp(i, (i == 3) ? 16'h0333 : 16'(16'h0600 + i));
        check_frame("t5a");
        strobe(0, 16'h7777);
        clr = 1'b1;
        rounder_valid = 1'b1;
        round_number  = 4'd9;
        tick();
        clr = 1'b0;
        rounder_valid = 1'b0;
        round_number  = '0;
        chk("t5_clr_err_idx", 32'(err_idx), 32'd0);
        chk("t5_clr_err_ovw", 32'(err_ovw), 32'd0);
        chk("t5_clr_frame_cnt", 32'(frame_cnt), 32'd0);
        for (int i = 1; i < NA; i++) strobe(i, 16'(16'h0700 + i));
        tick();
        chk("t5_slot0_cleared", 32'(keep), 32'd0);
        strobe(0, 16'h0700);
        wait_idle();
        for (int i = 0; i < NA; i++) push_exp(i, 16'(16'h0700 + i));
        check_frame("t5b");

        // 6: frame counter wrap
        force dut.frame_q = 16'hFFFE;
        m_frame = 16'hFFFE;
        tick();
        release dut.frame_q;
        for (int i = 0; i < NA; i++) strobe(i, 16'(i));
        wait_idle();
        chk("t6_frame_ffff", 32'(frame_cnt), 32'h0000FFFF);
        for (int i = 0; i < NA; i++) strobe(i, 16'(i));
        wait_idle();
        chk("t6_frame_wrap", 32'(frame_cnt), 32'd0);
        got_q.delete();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
